// File: rtl/axi_burst_pkg.sv
// Shared types, response codes and helpers for the AXI4 burst RAM slave.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int unsigned lane_bits(input int unsigned data_w);
    return $clog2(data_w / BYTE_W);
  endfunction

  // Word-index mask for a WRAP burst; illegal lengths round up to the next power of two.
  function automatic logic [7:0] wrap_mask(input logic [7:0] len);
    logic [7:0] m;
    m = len;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

  function automatic logic burst_err(input burst_t burst, input logic [7:0] len);
    return (burst == RSVD) ||
           ((burst == WRAP) && !((len == 8'd1) || (len == 8'd3) ||
                                 (len == 8'd7) || (len == 8'd15)));
  endfunction

  function automatic logic [1:0] resp_code(input logic dec, input logic slv);
    if (dec)      return RESP_DECERR;
    else if (slv) return RESP_SLVERR;
    else          return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat word-index generator for one AXI address channel (FIXED/INCR/WRAP).
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [IDX_W-1:0] start,
  input  logic [7:0]       len,
  input  burst_t           burst,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt_c,
  output logic             last,
  output logic             last_nxt_c,
  output logic             err_c
);

  logic [7:0]       cnt;
  logic [7:0]       len_q;
  burst_t           burst_q;
  logic [IDX_W-1:0] mask_q;

  // Index of the beat after the current one; reserved bursts advance like INCR.
  always_comb begin
    idx_nxt_c  = idx + IDX_W'(1);
    last_nxt_c = ((cnt + 8'd1) == len_q);
    err_c      = burst_err(burst, len);
    case (burst_q)
      FIXED:   idx_nxt_c = idx;
      WRAP:    idx_nxt_c = (idx & ~mask_q) | ((idx + IDX_W'(1)) & mask_q);
      default: idx_nxt_c = idx + IDX_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      burst_q <= FIXED;
      mask_q  <= '0;
      last    <= 1'b0;
    end else if (load) begin
      idx     <= start;
      cnt     <= '0;
      len_q   <= len;
      burst_q <= burst;
      mask_q  <= IDX_W'(wrap_mask(len));
      last    <= (len == 8'd0);
    end else if (step) begin
      idx     <= idx_nxt_c;
      cnt     <= cnt + 8'd1;
      last    <= last_nxt_c;
    end
  end

endmodule

// File: rtl/axi4_burst_ram_slave.sv
// AXI4 slave terminating a byte-writable on-chip RAM window with independent
// read and write channels, one outstanding transaction per direction.
module axi4_burst_ram_slave
  import axi_burst_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic [3:0]          s_axi_awregion,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic [3:0]          s_axi_arregion,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int unsigned STRB_W    = lane_count(DATA_W);
  localparam int unsigned LSB_W     = lane_bits(DATA_W);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam int unsigned OFF_W     = LSB_W + IDX_W;
  localparam logic [2:0]  FULL_SIZE = 3'(LSB_W);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DATA_W-1:0] mem [DEPTH];

  wstate_t          w_state;
  rstate_t          r_state;
  logic             w_dec_q;
  logic             w_slv_q;
  logic             r_dec_q;

  logic             aw_hs_c, w_hs_c, ar_hs_c, r_hs_c, r_step_c;
  logic             aw_dec_c, aw_slv_c, ar_dec_c, ar_slv_c, w_lmis_c;
  logic [IDX_W-1:0] aw_start_c, ar_start_c;
  logic [IDX_W-1:0] aw_idx, aw_idx_nxt_c, ar_idx, ar_idx_nxt_c;
  logic             aw_last, aw_last_nxt_c, ar_last, ar_last_nxt_c;
  logic             aw_err_c, ar_err_c;
  logic             unused_c;

  assign aw_hs_c  = s_axi_awvalid & s_axi_awready;
  assign w_hs_c   = s_axi_wvalid & s_axi_wready;
  assign ar_hs_c  = s_axi_arvalid & s_axi_arready;
  assign r_hs_c   = s_axi_rvalid & s_axi_rready;
  assign r_step_c = (r_state == R_DATA) & r_hs_c & ~s_axi_rlast;

  // Window decode compares everything above the window offset against the base.
  assign aw_dec_c   = (s_axi_awaddr >> OFF_W) != (BASE_ADDR >> OFF_W);
  assign ar_dec_c   = (s_axi_araddr >> OFF_W) != (BASE_ADDR >> OFF_W);
  assign aw_slv_c   = (s_axi_awsize != FULL_SIZE) | aw_err_c;
  assign ar_slv_c   = (s_axi_arsize != FULL_SIZE) | ar_err_c;
  assign aw_start_c = s_axi_awaddr[OFF_W-1:LSB_W];
  assign ar_start_c = s_axi_araddr[OFF_W-1:LSB_W];
  assign w_lmis_c   = s_axi_wlast != aw_last;

  assign unused_c = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                      s_axi_awregion, s_axi_arlock, s_axi_arcache, s_axi_arprot,
                      s_axi_arqos, s_axi_arregion, s_axi_awaddr[LSB_W-1:0],
                      s_axi_araddr[LSB_W-1:0], aw_idx_nxt_c, aw_last_nxt_c,
                      ar_idx, ar_last};

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_aw_gen (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .load       (aw_hs_c),
    .step       (w_hs_c),
    .start      (aw_start_c),
    .len        (s_axi_awlen),
    .burst      (burst_t'(s_axi_awburst)),
    .idx        (aw_idx),
    .idx_nxt_c  (aw_idx_nxt_c),
    .last       (aw_last),
    .last_nxt_c (aw_last_nxt_c),
    .err_c      (aw_err_c)
  );

  axi_burst_addr_gen #(.IDX_W(IDX_W)) u_ar_gen (
    .clk        (axi_aclk),
    .rst_n      (axi_aresetn),
    .load       (ar_hs_c),
    .step       (r_step_c),
    .start      (ar_start_c),
    .len        (s_axi_arlen),
    .burst      (burst_t'(s_axi_arburst)),
    .idx        (ar_idx),
    .idx_nxt_c  (ar_idx_nxt_c),
    .last       (ar_last),
    .last_nxt_c (ar_last_nxt_c),
    .err_c      (ar_err_c)
  );

  // Byte-lane RAM write; out-of-window bursts are consumed but dropped.
  always_ff @(posedge axi_aclk) begin
    if (w_hs_c && !w_dec_q) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[aw_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Write channel FSM; the beat counter, not wlast, ends the burst.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      w_dec_q       <= 1'b0;
      w_slv_q       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs_c) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_dec_q       <= aw_dec_c;
            w_slv_q       <= aw_slv_c;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs_c) begin
            if (w_lmis_c) w_slv_q <= 1'b1;
            if (aw_last) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= resp_code(w_dec_q, w_slv_q | w_lmis_c);
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM; each accepted beat fetches the next one on the same edge.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      r_dec_q       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs_c) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= ar_dec_c ? '0 : mem[ar_start_c];
            s_axi_rresp   <= resp_code(ar_dec_c, ar_slv_c);
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_dec_q       <= ar_dec_c;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs_c) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= r_dec_q ? '0 : mem[ar_idx_nxt_c];
              s_axi_rlast <= ar_last_nxt_c;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Directed bench for the AXI4 burst RAM slave, DATA_W=64, DEPTH=1024, BASE=0.
module tb_axi4_burst_ram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] wr_data [16];
  logic [63:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic        rd_first;
  logic [3:0]  rr_pat;
  logic [1:0]  resp;
  logic [1:0]  resp2;

  always #5 clk = ~clk;

  axi4_burst_ram_slave #(
    .DATA_W(64), .ADDR_W(32), .DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h0),
    .s_axi_awprot(3'h0), .s_axi_awqos(4'h0), .s_axi_awregion(4'h0),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h0),
    .s_axi_arprot(3'h0), .s_axi_arqos(4'h0), .s_axi_arregion(4'h0),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [2:0] s);
    int n;
    awaddr = a; awlen = l; awburst = b; awsize = s; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge clk); #1; n++; end
    check("aw_ready", 64'(awready), 64'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] st, input logic lst);
    int n;
    wdata = d; wstrb = st; wlast = lst; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 100) begin @(posedge clk); #1; n++; end
    check("w_ready", 64'(wready), 64'(1));
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] r);
    int n;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
    check("b_valid", 64'(bvalid), 64'(1));
    r = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                           input logic [2:0] s, input logic [7:0] st, input int lst_at,
                           output logic [1:0] r);
    aw_send(a, l, b, s);
    for (int i = 0; i <= int'(l); i++) w_beat(wr_data[i], st, i == lst_at);
    b_take(r);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b, input logic [2:0] s);
    int n;
    araddr = a; arlen = l; arburst = b; arsize = s; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    check("ar_ready", 64'(arready), 64'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                          input logic [2:0] s, input logic use_pat);
    int beat, cyc;
    logic [63:0] prev;
    logic stall;
    rready = 1'b0;
    ar_send(a, l, b, s);
    rd_first = rvalid;
    beat = 0; cyc = 0;
    while (beat <= int'(l) && beat < 16 && cyc < 200) begin
      rready = use_pat ? rr_pat[cyc % 4] : 1'b1;
      stall = rvalid && !rready;
      prev = rdata;
      if (rvalid && rready) begin
        rd_data[beat] = rdata; rd_resp[beat] = rresp; rd_last[beat] = rlast;
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
      if (stall) check("r_hold", rdata, prev);
    end
    rready = 1'b0;
    check("r_beats", 64'(beat), 64'(int'(l) + 1));
    check("r_done", 64'({rvalid, arready}), 64'(2'b01));
  endtask

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    rr_pat = 4'b1001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'({awready, arready, wready}), 64'(3'b110));
    check("rst_valid", 64'({bvalid, rvalid, rlast}), 64'(3'b000));
    check("rst_resp", 64'({bresp, rresp}), 64'(4'h0));
    check("rst_rdata", rdata, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR write then read back
    for (int i = 0; i < 4; i++) wr_data[i] = 64'(i + 1);
    axi_write(32'h100, 8'd3, 2'b01, 3'd3, 8'hFF, 3, resp);
    check("incr_bresp", 64'(resp), 64'(0));
    axi_read(32'h100, 8'd3, 2'b01, 3'd3, 1'b0);
    check("incr_first", 64'(rd_first), 64'(1));
    for (int i = 0; i < 4; i++) begin
      check("incr_data", rd_data[i], 64'(i + 1));
      check("incr_resp", 64'(rd_resp[i]), 64'(0));
      check("incr_last", 64'(rd_last[i]), 64'(i == 3));
    end

    // WRAP read from the middle of a 4-word block
    axi_read(32'h118, 8'd3, 2'b10, 3'd3, 1'b0);
    check("wrap_d0", rd_data[0], 64'd4);
    check("wrap_d1", rd_data[1], 64'd1);
    check("wrap_d2", rd_data[2], 64'd2);
    check("wrap_d3", rd_data[3], 64'd3);
    check("wrap_resp", 64'(rd_resp[3]), 64'(0));
    axi_read(32'h100, 8'd2, 2'b10, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) check("wrap_bad_resp", 64'(rd_resp[i]), 64'(2));
    check("wrap_bad_last", 64'({rd_last[0], rd_last[1], rd_last[2]}), 64'(3'b001));

    // Partial strobes
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(32'h200, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    wr_data[0] = 64'h0;
    axi_write(32'h200, 8'd0, 2'b01, 3'd3, 8'h0F, 0, resp2);
    check("strb_bresp", 64'({resp, resp2}), 64'(0));
    axi_read(32'h200, 8'd0, 2'b01, 3'd3, 1'b0);
    check("strb_data", rd_data[0], 64'hFFFF_FFFF_0000_0000);

    // Out-of-window accesses
    wr_data[0] = 64'h1111;
    axi_write(32'h0, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    wr_data[0] = 64'hDEAD;
    axi_write(32'h2000, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    check("dec_bresp", 64'(resp), 64'(3));
    axi_read(32'h0, 8'd0, 2'b01, 3'd3, 1'b0);
    check("dec_ram_kept", rd_data[0], 64'h1111);
    axi_read(32'h2000, 8'd1, 2'b01, 3'd3, 1'b0);
    check("dec_rdata", rd_data[0] | rd_data[1], 64'h0);
    check("dec_rresp", 64'({rd_resp[0], rd_resp[1]}), 64'(4'hF));

    // SLVERR sources: narrow size, reserved burst, early and late wlast
    wr_data[0] = 64'h77;
    axi_write(32'h300, 8'd0, 2'b01, 3'd2, 8'hFF, 0, resp);
    check("size_bresp", 64'(resp), 64'(2));
    axi_read(32'h300, 8'd0, 2'b01, 3'd3, 1'b0);
    check("size_data", rd_data[0], 64'h77);
    wr_data[0] = 64'h55; wr_data[1] = 64'h66;
    axi_write(32'h300, 8'd1, 2'b11, 3'd3, 8'hFF, 1, resp);
    check("rsvd_bresp", 64'(resp), 64'(2));
    axi_read(32'h300, 8'd1, 2'b01, 3'd3, 1'b0);
    check("rsvd_incr", {rd_data[0][31:0], rd_data[1][31:0]}, 64'h0000_0055_0000_0066);
    axi_write(32'h310, 8'd1, 2'b01, 3'd3, 8'hFF, 0, resp);
    check("early_wlast", 64'(resp), 64'(2));
    axi_write(32'h310, 8'd1, 2'b01, 3'd3, 8'hFF, 99, resp);
    check("late_wlast", 64'(resp), 64'(2));

    // FIXED burst: every beat lands on the same word
    wr_data[0] = 64'hA; wr_data[1] = 64'hB; wr_data[2] = 64'hC;
    axi_write(32'h900, 8'd2, 2'b00, 3'd3, 8'hFF, 2, resp);
    axi_read(32'h900, 8'd0, 2'b01, 3'd3, 1'b0);
    check("fixed_data", rd_data[0], 64'hC);

    // Stalled read stream with a concurrent write elsewhere
    for (int i = 0; i < 8; i++) wr_data[i] = 64'h1000 + 64'(i);
    axi_write(32'h400, 8'd7, 2'b01, 3'd3, 8'hFF, 7, resp);
    for (int i = 0; i < 4; i++) wr_data[i] = 64'h2000 + 64'(i);
    fork
      axi_write(32'h800, 8'd3, 2'b01, 3'd3, 8'hFF, 3, resp);
      axi_read(32'h400, 8'd7, 2'b01, 3'd3, 1'b1);
    join
    check("conc_bresp", 64'(resp), 64'(0));
    for (int i = 0; i < 8; i++) begin
      check("conc_rdata", rd_data[i], 64'h1000 + 64'(i));
      check("conc_rlast", 64'(rd_last[i]), 64'(i == 7));
    end
    axi_read(32'h800, 8'd3, 2'b01, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) check("conc_wdata", rd_data[i], 64'h2000 + 64'(i));

    // Reset pulse during beat 2 of an 8-beat write while a read beat is pending
    rready = 1'b0;
    ar_send(32'h400, 8'd0, 2'b01, 3'd3);
    check("mid_rvalid_pre", 64'(rvalid), 64'(1));
    aw_send(32'h600, 8'd7, 2'b01, 3'd3);
    w_beat(64'hA0, 8'hFF, 1'b0);
    w_beat(64'hA1, 8'hFF, 1'b0);
    wdata = 64'hA2; wstrb = 8'hFF; wvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valids", 64'({bvalid, rvalid, wready, rlast}), 64'(4'b0000));
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_ready", 64'({awready, arready}), 64'(2'b11));
    wr_data[0] = 64'h5A;
    axi_write(32'h600, 8'd0, 2'b01, 3'd3, 8'hFF, 0, resp);
    check("mid_new_bresp", 64'(resp), 64'(0));
    axi_read(32'h600, 8'd1, 2'b01, 3'd3, 1'b0);
    check("mid_new_data", rd_data[0], 64'h5A);
    check("mid_partial", rd_data[1], 64'hA1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_burst_ram_slave.md
Name: axi4_burst_ram_slave

Overview:
- Parametrised AXI4 full slave that terminates the PCIe-bridge AXI4 master port (M00_AXI_0 class: no ID signals) in the top level.
- Provides an on-chip, byte-writable RAM window for host DMA bring-up ahead of the DDR3 controller.
- Generalises to configurable data width and depth; supports FIXED/INCR/WRAP bursts, byte strobes, range decode and error responses.
- Read and write channels are independent; at most one outstanding transaction per direction.

Parameters:
- DATA_W, 64, data bus width in bits; one of 32, 64, 128, 256, 512.
- ADDR_W, 32, AXI address width.
- DEPTH, 1024, RAM words of DATA_W; must be a power of two.
- BASE_ADDR, 0, byte base address of the window, aligned to DEPTH*DATA_W/8.

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  reset
- s_axi_awaddr  in  ADDR_W  write address; s_axi_awlen in 8; s_axi_awsize in 3; s_axi_awburst in 2
- s_axi_awlock in 1; s_axi_awcache in 4; s_axi_awprot in 3; s_axi_awqos in 4; s_axi_awregion in 4  (accepted and ignored)
- s_axi_awvalid  in  1; s_axi_awready  out  1
- s_axi_wdata  in  DATA_W; s_axi_wstrb  in  DATA_W/8; s_axi_wlast  in  1; s_axi_wvalid  in  1; s_axi_wready  out  1
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1
- s_axi_araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion  in  same widths as AW
- s_axi_arvalid  in  1; s_axi_arready  out  1
- s_axi_rdata  out  DATA_W; s_axi_rresp  out  2; s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1

Behaviour:
- Clocking and reset: one clock, axi_aclk. Reset axi_aresetn is asynchronous, active-low.
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, rdata=0. RAM contents are not reset.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On the AW handshake, latch addr/len/size/burst, compute the error code, then go to W_DATA (awready=0, wready=1).
  - W_DATA: each W handshake writes bytes where wstrb=1, then advances the address via the generator. The beat with beat count == awlen moves to W_RESP regardless of wlast.
  - wlast mismatch (early or late) forces SLVERR.
  - W_RESP: bvalid=1 with bresp until bready, then W_IDLE with awready=1.
  - Minimum AW-to-next-AW turnaround is len+3 cycles.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - On the AR handshake in cycle N, beat 0 is valid in cycle N+1. rdata is registered.
  - Each R handshake loads the next beat in the same edge, so back-to-back beats stream at one per cycle while rready=1.
  - rvalid and rdata stay stable while rready=0.
  - rlast=1 on beat arlen. After its handshake, return to R_IDLE with arready=1.
- Address generation (per beat, word granularity):
  - FIXED(00): address constant.
  - INCR(01): +DATA_W/8 per beat, wraps modulo the window.
  - WRAP(10): wraps at a boundary of (len+1)*DATA_W/8.
  - Reserved(11): treated as INCR with SLVERR.
- Error responses, priority DECERR > SLVERR > OKAY. Response codes: OKAY=00, SLVERR=10, DECERR=11.
  - DECERR: start address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8). All beats are transferred; writes are dropped and reads return 0.
  - SLVERR: size != log2(DATA_W/8); burst=11; WRAP with len not in {1,3,7,15}; wlast mismatch. Data is still moved using full-width beats.
  - The error is reported on the single bresp, or on every rresp beat.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data. Channels never stall each other.
- Unaligned start addresses are truncated to word alignment.
- Reset asserted mid-burst: all valids drop immediately (asynchronous), FSMs return to idle, and any partial write remains in RAM.

Decomposition:
- Package axi_burst_pkg holds:
  - enum burst_t {FIXED, INCR, WRAP, RSVD};
  - constants RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - function wrap_mask(len);
  - localparam helpers for byte-lane count.
- Sub-module axi_burst_addr_gen, instantiated once for AW and once for AR:
  - inputs: start, len, burst, load, step;
  - outputs: word index, last-beat flag, error flag.

Test Plan:
- INCR write awaddr=0x100, awlen=3, wstrb all ones, data 1..4; then read the same -> bresp=00, rdata 1,2,3,4, rlast only on beat 3, beat 0 in the cycle after the AR handshake.
- WRAP read araddr=0x118, arlen=3, DATA_W=64 -> word order 0x118, 0x100, 0x108, 0x110. WRAP with arlen=2 -> rresp=10 on all 3 beats.
- Partial strobes: write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with wstrb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- Out-of-window awaddr=BASE+DEPTH*8 -> bresp=11 and RAM unchanged; araddr out of window, len=1 -> two beats, rdata=0, rresp=11.
- rready toggled 1-0-0-1 during an arlen=7 INCR read, with a concurrent write burst elsewhere -> rdata held stable while stalled, all 8 beats correct, write completes independently.
- axi_aresetn pulsed low mid-write (beat 2 of 8) -> bvalid and rvalid go 0 immediately; after release awready=arready=1 and a new transaction completes with OKAY.
